// File: rtl/pwm_level_sequencer.sv
// pwm_level_sequencer
//   Drives the 2-bit select of the 4:1 duty-preset mux in the LED dimmer path
//   and turns the selected duty into a registered PWM waveform. The select
//   steps through the four presets, either automatically after a programmable
//   number of PWM periods (auto mode) or on a step pulse (manual mode). Select
//   changes and duty reloads only happen at period boundaries, so pwm_out never
//   glitches.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       1 = run, 0 = idle with pwm_out low (select is held)
//   auto_mode    1 = advance after dwell periods, 0 = advance on step
//   step         one-clock advance request (manual mode only)
//   dwell        periods per level in auto mode (0 behaves as 1)
//   duty_in      duty from the preset mux (a function of select)
//   select       preset mux select
//   pwm_out      registered PWM output
//   period_tick  high on the last clock of each PWM period
//   level_done   one-clock pulse as select advances
module pwm_level_sequencer #(
  parameter int DUTY_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               auto_mode,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [DUTY_W-1:0]  duty_in,
  output logic [1:0]         select,
  output logic               pwm_out,
  output logic               period_tick,
  output logic               level_done
);

  typedef enum logic [1:0] {IDLE, AUTO, MANUAL} state_t;

  localparam logic [DUTY_W-1:0] CNT_MAX = '1;
  // Select moves one clock before the duty reload at CNT_MAX, so the duty of
  // the new preset is already on duty_in when the reload happens.
  localparam logic [DUTY_W-1:0] ADV_PT  = CNT_MAX - DUTY_W'(1);

  state_t              state, state_nx;
  logic [DUTY_W-1:0]   cnt, cnt_nx;
  logic [DUTY_W-1:0]   duty_q, duty_nx;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_cnt_nx;
  logic                step_pend, step_pend_nx;
  logic [1:0]          select_nx;
  logic                pwm_nx;
  logic                adv;
  logic                run, at_adv, at_max;

  // Last dwell_cnt value of a level; a dwell of 0 is treated as 1.
  function automatic logic [DWELL_W-1:0] dwell_last(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  assign run    = (state != IDLE);
  assign at_adv = run && (cnt == ADV_PT);
  assign at_max = run && (cnt == CNT_MAX);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    duty_nx      = duty_q;
    dwell_cnt_nx = dwell_cnt;
    step_pend_nx = step_pend;
    adv          = 1'b0;

    case (state)
      IDLE:    if (enable) state_nx = auto_mode ? AUTO : MANUAL;
      AUTO:    if (!enable) state_nx = IDLE;
               else if (!auto_mode) state_nx = MANUAL;
      MANUAL:  if (!enable) state_nx = IDLE;
               else if (auto_mode) state_nx = AUTO;
      default: state_nx = IDLE;
    endcase

    // Auto advance: ">=" rather than "==" so that a dwell lowered below the
    // current count still advances at the next advance point.
    if (state == AUTO && enable && at_adv) begin
      if (dwell_cnt >= dwell_last(dwell)) begin
        adv          = 1'b1;
        dwell_cnt_nx = '0;
      end else begin
        dwell_cnt_nx = dwell_cnt + DWELL_W'(1);
      end
    end

    // Manual advance: steps collapse into one pending request per period; a
    // step coincident with the advance point is honoured immediately.
    if (state == MANUAL && enable) begin
      if (at_adv) begin
        adv          = step_pend | step;
        step_pend_nx = 1'b0;
      end else begin
        step_pend_nx = step_pend | step;
      end
    end

    if (state == AUTO && state_nx == MANUAL) dwell_cnt_nx = '0;
    if (state == MANUAL && state_nx == AUTO) begin
      dwell_cnt_nx = '0;
      step_pend_nx = 1'b0;
    end

    if (state_nx == IDLE) begin
      cnt_nx       = '0;
      dwell_cnt_nx = '0;
      step_pend_nx = 1'b0;
    end else if (state == IDLE) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt + DUTY_W'(1);
    end

    if (at_max) duty_nx = duty_in;

    select_nx = adv ? select + 2'd1 : select;

    // pwm_out is computed from the next counter/duty so it lines up with cnt;
    // all-ones duty is forced high because cnt < MAX fails at cnt == MAX.
    pwm_nx = (state_nx != IDLE) && ((duty_nx == '1) || (cnt_nx < duty_nx));
  end

  assign period_tick = at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      duty_q     <= '0;
      dwell_cnt  <= '0;
      step_pend  <= 1'b0;
      select     <= 2'd0;
      pwm_out    <= 1'b0;
      level_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      duty_q     <= duty_nx;
      dwell_cnt  <= dwell_cnt_nx;
      step_pend  <= step_pend_nx;
      select     <= select_nx;
      pwm_out    <= pwm_nx;
      level_done <= adv;
    end
  end

endmodule

// File: tb/tb_pwm_level_sequencer.sv
// Testbench for pwm_level_sequencer: a table of per-period expectations
// (select at period start/end, PWM high count, level_done count, period_tick
// position) plus hand-written sequences for manual hold, enable drop, re-enable
// and reset during auto mode. The 4:1 preset mux is modelled in the bench.
module tb_pwm_level_sequencer;

  logic       clk = 1'b0;
  logic       rst, enable, auto_mode, step;
  logic [7:0] dwell;
  logic [3:0] duty_in;
  logic [1:0] select;
  logic       pwm_out, period_tick, level_done;

  logic [3:0] presets [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign duty_in = presets[select];

  pwm_level_sequencer #(.DUTY_W(4), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode), .step(step),
    .dwell(dwell), .duty_in(duty_in), .select(select), .pwm_out(pwm_out),
    .period_tick(period_tick), .level_done(level_done)
  );

  typedef struct {
    int          am;
    int          dw;
    logic [15:0] smask;
    int          set_duty;
    int          sel_s;
    int          sel_e;
    int          hi;
    int          done;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_presets(input int a, input int b, input int c, input int d);
    presets[0] = 4'(a); presets[1] = 4'(b); presets[2] = 4'(c); presets[3] = 4'(d);
  endtask

  // Runs one 16-clock period starting in the cnt==0 cycle and collects stats.
  task automatic run_period(input logic [15:0] smask, input int set_duty,
                            output int sel_s, output int sel_e, output int hi,
                            output int nd, output int tidx);
    int nt;
    hi = 0; nd = 0; nt = 0; tidx = -1; sel_s = 0; sel_e = 0;
    for (int i = 0; i < 16; i++) begin
      if (set_duty >= 0 && i == 5) set_presets(set_duty, set_duty, set_duty, set_duty);
      step = smask[i];
      if (i == 0)  sel_s = int'(select);
      if (i == 15) sel_e = int'(select);
      hi += int'(pwm_out);
      nd += int'(level_done);
      if (period_tick) begin
        nt++;
        tidx = i;
      end
      tick(1);
    end
    step = 1'b0;
    if (nt != 1) tidx = -1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ss, se, hi, nd, ti, bad;

    //             am dw smask     sd  ss se hi done
    tbl[0]  = '{1, 2, 16'h0000, -1, 0, 0, 0, 0};
    tbl[1]  = '{1, 2, 16'h0000, -1, 0, 1, 8, 1};
    tbl[2]  = '{1, 2, 16'h0000, -1, 1, 1, 4, 0};
    tbl[3]  = '{1, 2, 16'h0000, -1, 1, 2, 4, 1};
    tbl[4]  = '{1, 2, 16'h0000, -1, 2, 2, 2, 0};
    tbl[5]  = '{1, 2, 16'h0000, -1, 2, 3, 2, 1};
    tbl[6]  = '{1, 2, 16'h0000, -1, 3, 3, 1, 0};
    tbl[7]  = '{1, 2, 16'h0000, -1, 3, 0, 1, 1};
    tbl[8]  = '{1, 2, 16'h0000, -1, 0, 0, 8, 0};
    tbl[9]  = '{1, 2, 16'h0000, -1, 0, 1, 8, 1};
    tbl[10] = '{1, 0, 16'h0000, -1, 1, 2, 4, 1};
    tbl[11] = '{1, 0, 16'h0000, -1, 2, 3, 2, 1};
    tbl[12] = '{1, 0, 16'h0000, -1, 3, 0, 1, 1};
    tbl[13] = '{1, 1, 16'h0000, -1, 0, 1, 8, 1};
    tbl[14] = '{1, 1, 16'h0000, -1, 1, 2, 4, 1};
    tbl[15] = '{1, 3, 16'h0000, -1, 2, 2, 2, 0};
    tbl[16] = '{1, 3, 16'h0000, -1, 2, 2, 2, 0};
    tbl[17] = '{1, 1, 16'h0000, -1, 2, 3, 2, 1};
    tbl[18] = '{1, 1, 16'h0000, -1, 3, 0, 1, 1};
    tbl[19] = '{0, 1, 16'h0000, -1, 0, 0, 8, 0};
    tbl[20] = '{0, 1, 16'h0224, -1, 0, 1, 8, 1};
    tbl[21] = '{0, 1, 16'h4000, -1, 1, 2, 4, 1};
    tbl[22] = '{0, 1, 16'h8000, -1, 2, 2, 2, 0};
    tbl[23] = '{0, 1, 16'h0000, -1, 2, 3, 2, 1};
    tbl[24] = '{0, 1, 16'h0000, -1, 3, 3, 1, 0};
    tbl[25] = '{0, 1, 16'h0000, 15, 3, 3, 1, 0};
    tbl[26] = '{0, 1, 16'h0000, -1, 3, 3, 16, 0};
    tbl[27] = '{0, 1, 16'h0000,  0, 3, 3, 16, 0};
    tbl[28] = '{0, 1, 16'h0000, -1, 3, 3, 0, 0};

    set_presets(8, 4, 2, 1);
    rst = 1'b1; enable = 1'b0; auto_mode = 1'b0; step = 1'b0; dwell = 8'd0;

    // Reset state
    tick(2);
    chk("reset select", int'(select), 0);
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset period_tick", int'(period_tick), 0);
    chk("reset level_done", int'(level_done), 0);
    rst = 1'b0;
    tick(1);

    // Table: auto dwell 2/0/1/3->1, manual stepping, duty extremes
    enable = 1'b1; auto_mode = 1'b1; dwell = 8'd2;
    tick(1);
    for (int r = 0; r < 29; r++) begin
      auto_mode = tbl[r].am[0];
      dwell     = 8'(tbl[r].dw);
      run_period(tbl[r].smask, tbl[r].set_duty, ss, se, hi, nd, ti);
      chk($sformatf("row%0d sel_start", r), ss, tbl[r].sel_s);
      chk($sformatf("row%0d sel_end", r), se, tbl[r].sel_e);
      chk($sformatf("row%0d pwm_high", r), hi, tbl[r].hi);
      chk($sformatf("row%0d level_done", r), nd, tbl[r].done);
      chk($sformatf("row%0d tick_idx", r), ti, 15);
    end

    // Manual with no steps: select constant for 100 periods
    set_presets(8, 4, 2, 1);
    bad = 0;
    for (int p = 0; p < 100; p++) begin
      run_period(16'h0000, -1, ss, se, hi, nd, ti);
      if (ss != 3 || se != 3 || nd != 0 || ti != 15) bad++;
    end
    chk("manual hold bad periods", bad, 0);

    // Back to auto, dwell 1: 3 -> 0 -> 1 -> 2
    auto_mode = 1'b1; dwell = 8'd1;
    for (int p = 0; p < 3; p++) begin
      run_period(16'h0000, -1, ss, se, hi, nd, ti);
      chk($sformatf("auto resume p%0d sel_end", p), se, p);
    end

    // Hold select=2 in manual, drop enable mid-period
    auto_mode = 1'b0;
    tick(5);
    enable = 1'b0;
    tick(1);
    chk("idle pwm_out", int'(pwm_out), 0);
    chk("idle select", int'(select), 2);
    chk("idle period_tick", int'(period_tick), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out || period_tick || level_done || select != 2'd2) bad++;
      tick(1);
    end
    chk("idle quiet cycles", bad, 0);

    // Re-enable: fresh period from cnt 0 with the last loaded duty (2)
    set_presets(15, 15, 15, 15);
    enable = 1'b1;
    tick(1);
    run_period(16'h0000, -1, ss, se, hi, nd, ti);
    chk("reenable tick_idx", ti, 15);
    chk("reenable pwm_high", hi, 2);
    chk("reenable select", se, 2);

    // Reset in auto on the advance-point cycle with duty 15 loaded
    auto_mode = 1'b1; dwell = 8'd1;
    tick(14);
    rst = 1'b1;
    tick(1);
    chk("midrun rst select", int'(select), 0);
    chk("midrun rst pwm_out", int'(pwm_out), 0);
    chk("midrun rst period_tick", int'(period_tick), 0);
    chk("midrun rst level_done", int'(level_done), 0);
    rst = 1'b0;
    tick(1);
    run_period(16'h0000, -1, ss, se, hi, nd, ti);
    chk("post rst first period pwm_high", hi, 0);
    chk("post rst first period tick_idx", ti, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
